// File: rtl/hack_mem_pkg.sv
// Shared types, memory-map constants and the address decoder for the
// Hack data-port responder.
package hack_mem_pkg;

  // Responder transaction states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_WAIT = 2'd1,
    ST_SCR_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Memory-map regions seen by the CPU data port.
  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_SCR  = 2'd1,
    REG_KBD  = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  localparam logic [14:0] HACK_SCREEN_BASE = 15'h4000;
  localparam int unsigned SCREEN_WORDS     = 32'd8192;
  localparam logic [14:0] HACK_KBD_ADDR    = 15'h6000;

  // Classify a word address; RAM takes priority, compares are unsigned.
  function automatic region_e decode_region(
    input logic [14:0] addr,
    input int unsigned ram_words,
    input logic [14:0] scr_base,
    input logic [14:0] kbd_addr
  );
    region_e     region;
    logic [15:0] a16;
    logic [15:0] scr_lo;
    logic [15:0] scr_hi;
    a16    = {1'b0, addr};
    scr_lo = {1'b0, scr_base};
    scr_hi = scr_lo + 16'(SCREEN_WORDS);
    if ({17'd0, addr} < ram_words) begin
      region = REG_RAM;
    end else if ((a16 >= scr_lo) && (a16 < scr_hi)) begin
      region = REG_SCR;
    end else if (addr == kbd_addr) begin
      region = REG_KBD;
    end else begin
      region = REG_NONE;
    end
    return region;
  endfunction

endpackage

// File: rtl/hack_ram16k.sv
// Single-port data RAM: registered read, synchronous write. Contents are
// never cleared; only the read register is reset.
module hack_ram16k #(
  parameter int unsigned WORDS  = 32'd16384,
  parameter int unsigned ADDR_W = 32'd14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem_r [WORDS];
  logic [15:0] rdata_r;

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read; holds the last word read until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= 16'h0000;
    end else if (rd_en) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/hack_data_mem_responder.sv
// Memory-side responder for the Hack CPU data port. Each transaction reads
// first and commits any write on the edge leaving DONE, so M=M+1 style
// instructions complete in one transaction.
module hack_data_mem_responder
  import hack_mem_pkg::*;
#(
  parameter int unsigned RAM_WAIT    = 32'd1,
  parameter int unsigned RAM_WORDS   = 32'd16384,
  parameter logic [14:0] SCREEN_BASE = HACK_SCREEN_BASE,
  parameter logic [14:0] KBD_ADDR    = HACK_KBD_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic        ram_available,
  output logic [12:0] scr_addr,
  output logic        scr_rd_req,
  input  logic        scr_ack,
  input  logic [15:0] scr_rdata,
  output logic        scr_we,
  output logic [15:0] scr_wdata,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code
);

  localparam int unsigned AW          = $clog2(RAM_WORDS);
  localparam logic [3:0]  WAIT_LOAD   = 4'(RAM_WAIT - 32'd1);
  localparam bit          RAM_NO_WAIT = (RAM_WAIT == 32'd0);

  state_e          state_r;
  region_e         region_r;
  region_e         region_s;
  logic [AW-1:0]   addr_r;
  logic [3:0]      cnt_r;
  logic            avail_r;
  logic [15:0]     inm_r;
  logic            inm_from_ram_r;
  logic            scr_rd_req_r;
  logic            scr_we_r;
  logic [15:0]     scr_wdata_r;
  logic [12:0]     scr_addr_r;
  logic [12:0]     scr_off_s;
  logic [15:0]     kbd_r;
  logic            ram_rd_s;
  logic            ram_we_s;
  logic [AW-1:0]   ram_addr_s;
  logic [15:0]     ram_rdata_s;

  assign region_s  = decode_region(addressM, RAM_WORDS, SCREEN_BASE, KBD_ADDR);
  assign scr_off_s = 13'(addressM - SCREEN_BASE);

  // RAM port control: read at the edge entering DONE, write at the edge leaving it.
  always_comb begin
    ram_rd_s   = 1'b0;
    ram_we_s   = 1'b0;
    ram_addr_s = addr_r;
    case (state_r)
      ST_IDLE: begin
        ram_addr_s = addressM[AW-1:0];
        ram_rd_s   = mem_req && (region_s == REG_RAM) && RAM_NO_WAIT;
      end
      ST_RAM_WAIT: ram_rd_s = (cnt_r == 4'd0);
      ST_DONE:     ram_we_s = writeM && (region_r == REG_RAM);
      default:     ram_rd_s = 1'b0;
    endcase
  end

  // Transaction FSM with registered completion, read-data and screen outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      region_r       <= REG_NONE;
      addr_r         <= '0;
      cnt_r          <= 4'd0;
      avail_r        <= 1'b0;
      inm_r          <= 16'h0000;
      inm_from_ram_r <= 1'b0;
      scr_rd_req_r   <= 1'b0;
      scr_we_r       <= 1'b0;
      scr_wdata_r    <= 16'h0000;
      scr_addr_r     <= 13'd0;
    end else begin
      avail_r  <= 1'b0;
      scr_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_req) begin
            addr_r   <= addressM[AW-1:0];
            region_r <= region_s;
            case (region_s)
              REG_RAM: begin
                if (RAM_NO_WAIT) begin
                  state_r        <= ST_DONE;
                  avail_r        <= 1'b1;
                  inm_from_ram_r <= 1'b1;
                end else begin
                  cnt_r   <= WAIT_LOAD;
                  state_r <= ST_RAM_WAIT;
                end
              end
              REG_SCR: begin
                scr_addr_r   <= scr_off_s;
                scr_rd_req_r <= 1'b1;
                state_r      <= ST_SCR_WAIT;
              end
              REG_KBD: begin
                // Non-destructive read of the value latched before this edge.
                inm_r          <= kbd_r;
                inm_from_ram_r <= 1'b0;
                avail_r        <= 1'b1;
                state_r        <= ST_DONE;
              end
              default: begin
                inm_r          <= 16'h0000;
                inm_from_ram_r <= 1'b0;
                avail_r        <= 1'b1;
                state_r        <= ST_DONE;
              end
            endcase
          end
        end
        ST_RAM_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r        <= ST_DONE;
            avail_r        <= 1'b1;
            inm_from_ram_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_SCR_WAIT: begin
          if (scr_ack) begin
            inm_r          <= scr_rdata;
            inm_from_ram_r <= 1'b0;
            scr_rd_req_r   <= 1'b0;
            avail_r        <= 1'b1;
            state_r        <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          // Screen writes are posted as a single-cycle strobe.
          if (writeM && (region_r == REG_SCR)) begin
            scr_we_r    <= 1'b1;
            scr_wdata_r <= outM;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Keyboard latch, updated whenever the keyboard presents a code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_r <= 16'h0000;
    end else if (kbd_valid) begin
      kbd_r <= kbd_code;
    end
  end

  hack_ram16k #(
    .WORDS  (RAM_WORDS),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (ram_rd_s),
    .wr_en (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (outM),
    .rdata (ram_rdata_s)
  );

  // RAM data comes straight from the RAM's read register; other regions from inm_r.
  assign inM           = inm_from_ram_r ? ram_rdata_s : inm_r;
  assign ram_available = avail_r;
  assign scr_addr      = scr_addr_r;
  assign scr_rd_req    = scr_rd_req_r;
  assign scr_we        = scr_we_r;
  assign scr_wdata     = scr_wdata_r;

endmodule

// File: doc/hack_data_mem_responder.md
Name: hack_data_mem_responder

Overview:
- Memory-side responder for the Hack-style CPU data port. Serves CPU requests on addressM/outM/writeM and returns inM.
- Decodes the Hack memory map: RAM, screen, keyboard, unmapped space.
- Signals completion to the CPU stall logic with a one-cycle ram_available pulse.
- Every access is read-then-write, so a read-modify-write such as M=M+1 completes in a single transaction.

Parameters:
- RAM_WAIT, 1, extra wait cycles before a RAM access completes (0..15).
- RAM_WORDS, 16384, RAM depth in 16-bit words; RAM occupies 0x0000..RAM_WORDS-1.
- SCREEN_BASE, 15'h4000, first screen address; the screen window is 8192 words.
- KBD_ADDR, 15'h6000, keyboard register address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  in  1  CPU has a C-instruction that uses M (selM | writeM); held until ram_available is seen.
- addressM  in  15  word address; sampled in IDLE when mem_req=1.
- outM  in  16  write data; sampled in the DONE cycle.
- writeM  in  1  write enable; sampled in the DONE cycle.
- inM  out  16  read data; valid in DONE, held until the next read completes.
- ram_available  out  1  transaction complete; high exactly in DONE.
- scr_addr  out  13  screen word offset (addr_q - SCREEN_BASE).
- scr_rd_req  out  1  screen read request; held until scr_ack.
- scr_ack  in  1  screen read data valid.
- scr_rdata  in  16  screen read data.
- scr_we  out  1  one-cycle posted screen write strobe.
- scr_wdata  out  16  screen write data, valid with scr_we.
- kbd_valid  in  1  latch kbd_code this cycle.
- kbd_code  in  16  scan code; 0 means no key.

Interface decision: one clock, clk. Reset is asynchronous and active-high, named reset.

Behaviour:
- Reset (async): state=IDLE, ram_available=0, inM=0, scr_rd_req=0, scr_we=0, scr_wdata=0, scr_addr=0, kbd_reg=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-transaction aborts it with no write committed.
- FSM states: IDLE, RAM_WAIT, SCR_WAIT, DONE.
- IDLE:
  - If mem_req=1: capture addr_q=addressM and decode region.
  - RAM region (addr < RAM_WORDS):
    - RAM_WAIT=0: issue the RAM read and go to DONE.
    - Otherwise: load cnt=RAM_WAIT-1 and go to RAM_WAIT.
  - Screen region (SCREEN_BASE <= addr < SCREEN_BASE+8192): assert scr_rd_req and go to SCR_WAIT.
  - KBD_ADDR: inM <= kbd_reg, go to DONE.
  - Unmapped: inM <= 0, go to DONE.
- RAM_WAIT:
  - cnt==0: issue the RAM read (registered), go to DONE.
  - Otherwise: cnt decrements.
- SCR_WAIT: on scr_ack, inM <= scr_rdata, drop scr_rd_req, go to DONE. No timeout.
- DONE:
  - ram_available=1; the CPU executes the instruction this cycle.
  - At the edge leaving DONE, if writeM=1:
    - RAM: write outM to RAM[addr_q].
    - Screen: register scr_we=1 and scr_wdata=outM for the next cycle only.
    - Keyboard or unmapped: the write is ignored.
  - Always DONE -> IDLE.
- Latency, mem_req to ram_available:
  - RAM: RAM_WAIT+1 cycles.
  - Keyboard or unmapped: 1 cycle.
  - Screen: 1 cycle + ack delay.
- Back-to-back requests: an IDLE cycle always separates two transactions. mem_req still high in that IDLE cycle starts a new transaction at the current addressM.
- mem_req dropping mid-transaction does not abort: the transaction still completes, ram_available still pulses, and a write is committed if writeM=1 in DONE.
- addressM changes after capture are ignored.
- RAM reads see the old value in DONE, so read-before-write holds.
- Keyboard: kbd_reg <= kbd_code on any cycle with kbd_valid=1, including during a transaction. Reads are non-destructive. If kbd_valid coincides with an IDLE keyboard capture, inM gets the pre-update kbd_reg.
- Width rules: 15-bit address compares are unsigned. scr_addr is the low 13 bits of (addr_q - SCREEN_BASE).

Decomposition:
- Shared package hack_mem_pkg:
  - state enum (IDLE, RAM_WAIT, SCR_WAIT, DONE);
  - region enum (REG_RAM, REG_SCR, REG_KBD, REG_NONE);
  - SCREEN_BASE, SCREEN_WORDS=8192, KBD_ADDR constants;
  - address-decode function.
- Sub-module hack_ram16k: single-port synchronous RAM with registered read and synchronous write, RAM_WORDS x 16. Instantiated once.

Test Plan:
- Reset, RAM_WAIT=1: mem_req=1, addr=0x0010, writeM=0 -> ram_available high on cycle 2 only; inM=0x0000 in DONE. Preloaded 0x1234 -> inM=0x1234.
- Read-modify-write: RAM[5]=0x0007; req addr=5 with writeM=1 and outM=inM+1 in DONE -> inM=0x0007 in DONE; a following read of RAM[5] returns 0x0008.
- Screen: req addr=0x4005, scr_ack after 3 cycles with scr_rdata=0xBEEF -> scr_addr=5, scr_rd_req high until ack, inM=0xBEEF; a write with outM=0x00FF pulses scr_we one cycle after DONE with scr_wdata=0x00FF.
- Keyboard: kbd_valid pulse with 0x0041; read 0x6000 -> inM=0x0041 after 1 cycle. A write to 0x6000 leaves kbd_reg unchanged. Read of 0x7000 -> inM=0.
- Async reset asserted in RAM_WAIT with writeM=1 -> ram_available=0 and state IDLE immediately; a later read shows RAM unchanged.
- RAM_WAIT=0 back-to-back reads of 0x0001 then 0x0002 -> ram_available pulses 2 cycles apart with correct inM each time; an addressM change during RAM_WAIT (RAM_WAIT=3) has no effect.
